// File: rtl/x_mem_pkg.sv
// Shared encodings for the activation memory: host command codes,
// controller state encodings and the fixed bank roles.
package x_mem_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_CLEAR = 2'b01,
        CMD_LOAD  = 2'b10,
        CMD_DUMP  = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        DUMP  = 3'd3,
        FIN   = 3'd4
    } state_e;

    localparam int BANK_IN = 0;
    localparam int BANK_L1 = 1;
    localparam int BANK_L2 = 2;
    localparam int BANK_L3 = 3;

endpackage

// File: rtl/x_act_mem_if.sv
// Bundle of the compute-side request port and the host-side command,
// load-stream and dump-stream signals of the activation memory.
// The memory side uses the slave modport; whoever drives requests uses master.
interface x_act_mem_if #(
    parameter int X_ADDR_LEN = 10,
    parameter int X_SEL_LEN  = 2,
    parameter int X_DATA_LEN = 1
);
    logic [X_ADDR_LEN-1:0] x_addr;
    logic [X_SEL_LEN-1:0]  x_sel;
    logic                  x_wq;
    logic                  wx_write;
    logic [X_DATA_LEN-1:0] x_data;

    logic [1:0]            h_cmd;
    logic                  h_cmd_valid;
    logic [X_SEL_LEN-1:0]  h_sel;
    logic [X_ADDR_LEN:0]   h_len;
    logic                  h_in_valid;
    logic                  h_in_data;
    logic                  h_in_ready;
    logic                  h_out_valid;
    logic                  h_out_data;
    logic                  h_out_last;
    logic                  h_out_ready;
    logic                  busy;
    logic                  done;
    logic                  err_oor;
    logic                  err_clr;

    modport master (
        output x_addr, x_sel, x_wq, wx_write,
        output h_cmd, h_cmd_valid, h_sel, h_len, h_in_valid, h_in_data,
        output h_out_ready, err_clr,
        input  x_data, h_in_ready, h_out_valid, h_out_data, h_out_last,
        input  busy, done, err_oor
    );

    modport slave (
        input  x_addr, x_sel, x_wq, wx_write,
        input  h_cmd, h_cmd_valid, h_sel, h_len, h_in_valid, h_in_data,
        input  h_out_ready, err_clr,
        output x_data, h_in_ready, h_out_valid, h_out_data, h_out_last,
        output busy, done, err_oor
    );
endinterface

// File: rtl/x_bank_ram.sv
// One single-bit activation bank: synchronous read every cycle, one write
// port sharing the same address, read-before-write, no reset on contents.
module x_bank_ram #(
    parameter int X_ADDR_LEN = 10,
    parameter int X_DEPTH    = 1024
) (
    input  logic                  i_clk,
    input  logic [X_ADDR_LEN-1:0] i_addr,
    input  logic                  i_we,
    input  logic                  i_wdata,
    output logic                  o_rdata
);
    logic r_mem [X_DEPTH];
    logic r_rdata;

    // Registered read of the addressed bit; a same-cycle write lands after the read.
    always_ff @(posedge i_clk) begin
        r_rdata <= r_mem[i_addr];
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/x_act_mem.sv
// Activation memory responder: NUM_BANKS single-bit banks shared between the
// compute port (owner while idle) and a host command port that can clear all
// banks, stream-load one bank and stream-dump one bank.
module x_act_mem
    import x_mem_pkg::*;
#(
    parameter int X_ADDR_LEN = 10,
    parameter int X_SEL_LEN  = 2,
    parameter int X_DATA_LEN = 1,
    parameter int X_DEPTH    = 1024,
    parameter int NUM_BANKS  = 4
) (
    input  logic        clk,
    input  logic        rst,
    x_act_mem_if.slave  io_bus
);
    localparam int                   CW        = X_ADDR_LEN + 1;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(X_DEPTH);
    localparam logic [CW-1:0]        LAST_ADDR = CW'(X_DEPTH - 1);
    localparam logic [X_SEL_LEN:0]   NBANK_C   = (X_SEL_LEN + 1)'(NUM_BANKS);
    localparam logic [X_SEL_LEN-1:0] LAST_BANK = X_SEL_LEN'(NUM_BANKS - 1);

    state_e                r_state, w_stateNext;
    logic [CW-1:0]         r_cnt, w_cntNext;
    logic [CW-1:0]         r_len, w_lenNext;
    logic [X_SEL_LEN-1:0]  r_sel, w_selNext;
    logic                  r_outValid, w_outValidNext;
    logic                  r_rdOk;
    logic [X_SEL_LEN-1:0]  r_rdBank;
    logic                  r_errOor;

    cmd_e                  w_cmd;
    logic                  w_idle;
    logic                  w_xInRange;
    logic                  w_hSelOk;
    logic                  w_lastBit;
    logic                  w_ramWe;
    logic                  w_ramWdata;
    logic [X_SEL_LEN-1:0]  w_ramBank;
    logic [X_ADDR_LEN-1:0] w_ramAddr;
    logic [NUM_BANKS-1:0]  w_bankWe;
    logic [NUM_BANKS-1:0]  w_bankRdata;
    logic                  w_rdMux;

    assign w_cmd      = cmd_e'(io_bus.h_cmd);
    assign w_idle     = (r_state == IDLE);
    assign w_xInRange = ({1'b0, io_bus.x_addr} < DEPTH_C) && ({1'b0, io_bus.x_sel} < NBANK_C);
    assign w_hSelOk   = ({1'b0, io_bus.h_sel} < NBANK_C);
    assign w_lastBit  = (r_cnt == r_len - CW'(1));

    // Next-state logic: command acceptance in IDLE and per-operation sequencing.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_lenNext      = r_len;
        w_selNext      = r_sel;
        w_outValidNext = r_outValid;
        case (r_state)
            IDLE: begin
                if (io_bus.h_cmd_valid && (w_cmd != CMD_NOP)) begin
                    w_cntNext = '0;
                    w_lenNext = (io_bus.h_len > DEPTH_C) ? DEPTH_C : io_bus.h_len;
                    w_selNext = io_bus.h_sel;
                    if (w_cmd == CMD_CLEAR) begin
                        w_selNext   = X_SEL_LEN'(BANK_IN);
                        w_stateNext = CLEAR;
                    end else if (!w_hSelOk || (io_bus.h_len == '0)) begin
                        w_stateNext = FIN;
                    end else if (w_cmd == CMD_LOAD) begin
                        w_stateNext = LOAD;
                    end else begin
                        w_stateNext = DUMP;
                    end
                end
            end
            CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_cntNext = '0;
                    if (r_sel == LAST_BANK) begin
                        w_stateNext = FIN;
                    end else begin
                        w_selNext = r_sel + X_SEL_LEN'(1);
                    end
                end else begin
                    w_cntNext = r_cnt + CW'(1);
                end
            end
            LOAD: begin
                if (io_bus.h_in_valid) begin
                    w_cntNext = r_cnt + CW'(1);
                    if (r_cnt + CW'(1) == r_len) begin
                        w_stateNext = FIN;
                    end
                end
            end
            DUMP: begin
                if (!r_outValid) begin
                    w_outValidNext = 1'b1;
                end else if (io_bus.h_out_ready) begin
                    w_outValidNext = 1'b0;
                    if (w_lastBit) begin
                        w_stateNext = FIN;
                    end else begin
                        w_cntNext = r_cnt + CW'(1);
                    end
                end
            end
            FIN: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Controller registers; reset aborts any host operation without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_len      <= '0;
            r_sel      <= '0;
            r_outValid <= 1'b0;
            r_rdOk     <= 1'b0;
            r_rdBank   <= '0;
            r_errOor   <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_len      <= w_lenNext;
            r_sel      <= w_selNext;
            r_outValid <= w_outValidNext;
            r_rdOk     <= w_idle && w_xInRange;
            r_rdBank   <= w_ramBank;
            if (w_idle && !w_xInRange) begin
                r_errOor <= 1'b1;
            end else if (io_bus.err_clr) begin
                r_errOor <= 1'b0;
            end
        end
    end

    // Memory port mux: compute port while idle, host sequencer otherwise.
    always_comb begin
        w_ramBank  = r_sel;
        w_ramAddr  = r_cnt[X_ADDR_LEN-1:0];
        w_ramWe    = 1'b0;
        w_ramWdata = 1'b0;
        case (r_state)
            IDLE: begin
                w_ramBank  = io_bus.x_sel;
                w_ramAddr  = io_bus.x_addr;
                w_ramWe    = io_bus.x_wq && w_xInRange;
                w_ramWdata = io_bus.wx_write;
            end
            CLEAR: begin
                w_ramWe = 1'b1;
            end
            LOAD: begin
                w_ramWe    = io_bus.h_in_valid;
                w_ramWdata = io_bus.h_in_data;
            end
            default: begin
            end
        endcase
    end

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign w_bankWe[gi] = w_ramWe && (w_ramBank == X_SEL_LEN'(gi));
        x_bank_ram #(
            .X_ADDR_LEN (X_ADDR_LEN),
            .X_DEPTH    (X_DEPTH)
        ) u_bank (
            .i_clk   (clk),
            .i_addr  (w_ramAddr),
            .i_we    (w_bankWe[gi]),
            .i_wdata (w_ramWdata),
            .o_rdata (w_bankRdata[gi])
        );
    end

    // Select the bank whose read was issued on the previous cycle.
    always_comb begin
        w_rdMux = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_rdBank == X_SEL_LEN'(i)) begin
                w_rdMux = w_bankRdata[i];
            end
        end
    end

    assign io_bus.x_data      = X_DATA_LEN'(r_rdOk & w_rdMux);
    assign io_bus.h_in_ready  = (r_state == LOAD);
    assign io_bus.h_out_valid = r_outValid;
    assign io_bus.h_out_data  = r_outValid & w_rdMux;
    assign io_bus.h_out_last  = r_outValid && (r_state == DUMP) && w_lastBit;
    assign io_bus.busy        = (r_state == CLEAR) || (r_state == LOAD) || (r_state == DUMP);
    assign io_bus.done        = (r_state == FIN);
    assign io_bus.err_oor     = r_errOor;
endmodule
